free_list: RTL and testbench

- Circular FIFO of free physical register tags for the R10K rename path.
- At dispatch it supplies T_new to the ROB and Map Table.
- At retire it reclaims T_old coming out of the ROB.
- It holds a single branch checkpoint of the head pointer. On a mispredict it restores that pointer, so tags allocated on the wrong path are freed in one cycle.

---
 rtl/free_list_pkg.sv | 18 +
 rtl/free_list.sv | 85 ++++++++
 tb/tb_free_list.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared sizes, tag/pointer types and the no-destination marker for the free list
package free_list_pkg;

  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_ARCH_REG = 32;
  localparam int FL_SIZE      = NUM_PHYS_REG - NUM_ARCH_REG;

  localparam int TAG_W    = $clog2(NUM_PHYS_REG);
  localparam int PHYS_REG = TAG_W + 1;
  localparam int PTR_W    = $clog2(FL_SIZE) + 1;

  // All-ones marks "instruction had no destination" on the retire path
  localparam logic [PHYS_REG-1:0] DUMMY_REG = '1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/free_list.sv
// rtl/free_list.sv - circular free-tag FIFO with a single head-pointer branch checkpoint
module free_list
  import free_list_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                dispatch_en,
  input  logic                retire_en,
  input  logic [PHYS_REG-1:0] T_old_in,
  input  logic                checkpoint_en,
  input  logic                branch_mispredict,
  output logic [PHYS_REG-1:0] T_new_out,
  output logic                T_new_valid,
  output logic [PTR_W-1:0]    free_count,
  output logic                fl_empty
);

  tag_t    entries_q [FL_SIZE];
  tag_t    entries_d [FL_SIZE];
  fl_ptr_t head_q, head_d;
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t ckpt_q, ckpt_d;
  fl_ptr_t count_q, count_d;

  logic push_req, push, pop, mispredict;

  assign fl_empty    = (count_q == '0);
  assign T_new_valid = !fl_empty;
  assign T_new_out   = {1'b0, entries_q[head_q[PTR_W-2:0]]};
  assign free_count  = count_q;

  always_comb begin
    mispredict = enable && branch_mispredict;
    push_req   = enable && retire_en && (T_old_in != DUMMY_REG);
    push       = push_req && (count_q != fl_ptr_t'(FL_SIZE));
    pop        = enable && dispatch_en && !fl_empty && !branch_mispredict;

    entries_d = entries_q;
    if (push) begin
      entries_d[tail_q[PTR_W-2:0]] = T_old_in[TAG_W-1:0];
    end
    tail_d = tail_q + fl_ptr_t'(push);

    // The checkpoint is taken from the start-of-cycle head; a mispredict in
    // the same cycle keeps the old snapshot so the restore target is stable.
    ckpt_d = (enable && checkpoint_en && !branch_mispredict) ? head_q : ckpt_q;

    if (mispredict) begin
      head_d  = ckpt_q;
      count_d = tail_d - ckpt_q;
    end else begin
      head_d  = head_q + fl_ptr_t'(pop);
      count_d = count_q + fl_ptr_t'(push) - fl_ptr_t'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entries_q[i] <= tag_t'(NUM_ARCH_REG + i);
      end
      head_q  <= '0;
      tail_q  <= fl_ptr_t'(FL_SIZE);
      ckpt_q  <= '0;
      count_q <= fl_ptr_t'(FL_SIZE);
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      ckpt_q    <= ckpt_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push_req && count_q == fl_ptr_t'(FL_SIZE)))
        else $error("free_list: push while full, tag dropped");
      assert (count_q == fl_ptr_t'(tail_q - head_q))
        else $error("free_list: free_count disagrees with tail-head");
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed self-checking bench for free_list
module tb_free_list;
  import free_list_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                enable;
  logic                dispatch_en;
  logic                retire_en;
  logic [PHYS_REG-1:0] T_old_in;
  logic                checkpoint_en;
  logic                branch_mispredict;
  logic [PHYS_REG-1:0] T_new_out;
  logic                T_new_valid;
  logic [PTR_W-1:0]    free_count;
  logic                fl_empty;

  int errors = 0;
  int checks = 0;

  free_list dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .dispatch_en       (dispatch_en),
    .retire_en         (retire_en),
    .T_old_in          (T_old_in),
    .checkpoint_en     (checkpoint_en),
    .branch_mispredict (branch_mispredict),
    .T_new_out         (T_new_out),
    .T_new_valid       (T_new_valid),
    .free_count        (free_count),
    .fl_empty          (fl_empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    dispatch_en       = 1'b0;
    retire_en         = 1'b0;
    T_old_in          = '0;
    checkpoint_en     = 1'b0;
    branch_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    enable = 1'b1;
    do_reset();
    step();
    check("reset_count", free_count, 32);
    check("reset_tnew", T_new_out, 7'b0100000);
    check("reset_valid", T_new_valid, 1);
    check("reset_empty", fl_empty, 0);

    dispatch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pop_tnew_%0d", i), T_new_out, 32 + i);
      step();
    end
    check("pop3_tnew", T_new_out, 35);
    check("pop3_count", free_count, 29);

    for (int i = 0; i < 29; i++) step();
    check("drain_empty", fl_empty, 1);
    check("drain_valid", T_new_valid, 0);
    check("drain_count", free_count, 0);

    step();
    check("empty_pop_ignored", free_count, 0);

    retire_en = 1'b1;
    T_old_in  = 7'd5;
    step();
    idle();
    check("push_on_empty_tnew", T_new_out, 5);
    check("push_on_empty_count", free_count, 1);

    retire_en = 1'b1;
    T_old_in  = DUMMY_REG;
    step();
    idle();
    check("dummy_count", free_count, 1);
    check("dummy_tnew", T_new_out, 5);

    do_reset();
    dispatch_en = 1'b1;
    step();
    step();
    check("pre_ckpt_tnew", T_new_out, 34);
    checkpoint_en = 1'b1;
    step();
    checkpoint_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    dispatch_en = 1'b0;
    check("wrong_path_tnew", T_new_out, 38);
    check("wrong_path_count", free_count, 26);

    dispatch_en       = 1'b1;
    branch_mispredict = 1'b1;
    step();
    idle();
    check("mispredict_tnew", T_new_out, 34);
    check("mispredict_count", free_count, 30);

    dispatch_en = 1'b1;
    step();
    step();
    branch_mispredict = 1'b1;
    retire_en         = 1'b1;
    T_old_in          = 7'd7;
    step();
    idle();
    check("mispredict_push_tnew", T_new_out, 34);
    check("mispredict_push_count", free_count, 31);

    dispatch_en = 1'b1;
    step();
    dispatch_en       = 1'b0;
    checkpoint_en     = 1'b1;
    branch_mispredict = 1'b1;
    step();
    idle();
    check("ckpt_vs_mispredict_tnew", T_new_out, 34);
    dispatch_en = 1'b1;
    step();
    step();
    dispatch_en       = 1'b0;
    branch_mispredict = 1'b1;
    step();
    idle();
    check("ckpt_kept_tnew", T_new_out, 34);
    check("ckpt_kept_count", free_count, 31);

    enable        = 1'b0;
    dispatch_en   = 1'b1;
    retire_en     = 1'b1;
    T_old_in      = 7'd9;
    checkpoint_en = 1'b1;
    step();
    step();
    check("disabled_count", free_count, 31);
    check("disabled_tnew", T_new_out, 34);

    enable = 1'b1;
    idle();
    dispatch_en = 1'b1;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    idle();
    check("midreset_count", free_count, 32);
    check("midreset_tnew", T_new_out, 32);
    check("midreset_valid", T_new_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
